// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction/timing game controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_SCORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_EASY = 2'd0;
    localparam logic [1:0] MODE_MED  = 2'd1;
    localparam logic [1:0] MODE_HARD = 2'd2;

    // Clock cycles per count increment for the selected difficulty.
    function automatic int unsigned PERIOD(input logic [1:0] mode,
                                           input int unsigned easy_t,
                                           input int unsigned med_t,
                                           input int unsigned hard_t);
        case (mode)
            MODE_EASY: return easy_t;
            MODE_MED:  return med_t;
            default:   return hard_t;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Turns a debounced button level into a single-cycle press pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = btn_i;

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end

    assign pulse_o = btn_i & ~prev_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction game: pick difficulty, show target, run a blind
// counter, score the stop distance and accumulate over ROUNDS rounds.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_W      = 14,
    parameter int unsigned LED_N      = 16,
    parameter int unsigned BUCKET     = 30,
    parameter int unsigned ROUNDS     = 3,
    parameter int unsigned EASY_TICKS = 1000000,
    parameter int unsigned MED_TICKS  = 200000,
    parameter int unsigned HARD_TICKS = 100000,
    parameter int unsigned TICK_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_sel,
    input  logic [NUM_W-1:0] rand_in,
    output logic [2:0]       state_o,
    output logic [1:0]       mode_o,
    output logic [NUM_W-1:0] number_o,
    output logic [3:0]       round_o,
    output logic [LED_N-1:0] led_o,
    output logic [NUM_W+3:0] total_o,
    output logic             done_o
);

    localparam logic [LED_N-1:0] LED_ONES = '1;

    logic up_p, down_p, sel_p;

    btn_edge u_up   (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),   .pulse_o(up_p));
    btn_edge u_down (.clk(clk), .rst_n(rst_n), .btn_i(btn_down), .pulse_o(down_p));
    btn_edge u_sel  (.clk(clk), .rst_n(rst_n), .btn_i(btn_sel),  .pulse_o(sel_p));

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [NUM_W-1:0]  number_q, number_d;
    logic [NUM_W-1:0]  target_q, target_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        round_q, round_d;
    logic [LED_N-1:0]  led_q, led_d;
    logic [NUM_W+3:0]  total_q, total_d;
    logic              score_first_q, score_first_d;

    logic [TICK_W-1:0] period_m1;
    logic [NUM_W-1:0]  score;
    int unsigned       off;
    logic [LED_N-1:0]  led_score;
    logic [NUM_W+4:0]  sum;
    logic [NUM_W+3:0]  total_score;
    logic              last_round;

    assign period_m1  = TICK_W'(PERIOD(mode_q, EASY_TICKS, MED_TICKS, HARD_TICKS) - 1);
    assign last_round = (round_q >= 4'(ROUNDS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= MODE_MED;
            number_q      <= '0;
            target_q      <= '0;
            tick_q        <= '0;
            round_q       <= 4'd1;
            led_q         <= '0;
            total_q       <= '0;
            score_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            number_q      <= number_d;
            target_q      <= target_d;
            tick_q        <= tick_d;
            round_q       <= round_d;
            led_q         <= led_d;
            total_q       <= total_d;
            score_first_q <= score_first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_p) state_d = S_ARM;
            S_ARM:   if (sel_p) state_d = S_RUN;
            S_RUN:   if (sel_p) state_d = S_SCORE;
            S_SCORE: if (!score_first_q && sel_p) state_d = last_round ? S_DONE : S_ARM;
            S_DONE:  if (sel_p) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Distance score, LED bar and saturating running total for this round.
    always_comb begin
        score = (number_q >= target_q) ? (number_q - target_q) : (target_q - number_q);
        off   = 32'(score) / BUCKET;
        if (off > LED_N) off = LED_N;
        led_score   = LED_ONES << off;
        sum         = {1'b0, total_q} + (NUM_W+5)'(score);
        total_score = sum[NUM_W+4] ? '1 : sum[NUM_W+3:0];
    end

    always_comb begin
        mode_d        = mode_q;
        number_d      = number_q;
        target_d      = target_q;
        tick_d        = tick_q;
        round_d       = round_q;
        led_d         = led_q;
        total_d       = total_q;
        score_first_d = 1'b0;

        // Target is latched on every transition into ARM (from IDLE or SCORE).
        if (state_d == S_ARM && state_q != S_ARM) begin
            target_d = (rand_in == '0) ? NUM_W'(1) : rand_in;
            number_d = target_d;
        end

        case (state_q)
            S_IDLE: begin
                if (!sel_p) begin
                    if (up_p && !down_p && mode_q < MODE_HARD) mode_d = mode_q + 2'd1;
                    if (down_p && !up_p && mode_q > MODE_EASY) mode_d = mode_q - 2'd1;
                end
            end
            S_ARM: begin
                if (sel_p) begin
                    number_d = '0;
                    tick_d   = '0;
                end
            end
            S_RUN: begin
                if (sel_p) begin
                    score_first_d = 1'b1;
                end else if (tick_q == period_m1) begin
                    tick_d = '0;
                    if (number_q != '1) number_d = number_q + NUM_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_SCORE: begin
                if (score_first_q) begin
                    led_d   = led_score;
                    total_d = total_score;
                end else if (sel_p && !last_round) begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (sel_p) begin
                    round_d  = 4'd1;
                    total_d  = '0;
                    led_d    = '0;
                    number_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_o  = state_q;
        done_o   = (state_q == S_DONE);
        number_o = (state_q == S_DONE) ? total_q[NUM_W-1:0] : number_q;
    end

    assign mode_o  = mode_q;
    assign round_o = round_q;
    assign led_o   = led_q;
    assign total_o = total_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl: mode table, round table, and
// hand-written sequences for saturation and mid-RUN reset.
module tb_reaction_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
    logic [13:0] rand_in = '0;

    logic [2:0]  state_a;
    logic [1:0]  mode_a;
    logic [13:0] number_a;
    logic [3:0]  round_a;
    logic [15:0] led_a;
    logic [17:0] total_a;
    logic        done_a;

    logic [2:0]  state_b;
    logic [1:0]  mode_b;
    logic [3:0]  number_b;
    logic [3:0]  round_b;
    logic [15:0] led_b;
    logic [7:0]  total_b;
    logic        done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_game_ctrl #(
        .NUM_W(14), .LED_N(16), .BUCKET(30), .ROUNDS(3),
        .EASY_TICKS(4), .MED_TICKS(3), .HARD_TICKS(2), .TICK_W(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .rand_in(rand_in), .state_o(state_a), .mode_o(mode_a),
        .number_o(number_a), .round_o(round_a), .led_o(led_a), .total_o(total_a),
        .done_o(done_a)
    );

    // Narrow instance driven in lockstep, used for the count saturation check.
    reaction_game_ctrl #(
        .NUM_W(4), .LED_N(16), .BUCKET(30), .ROUNDS(3),
        .EASY_TICKS(4), .MED_TICKS(3), .HARD_TICKS(2), .TICK_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_sel(btn_sel), .rand_in(rand_in[3:0]), .state_o(state_b), .mode_o(mode_b),
        .number_o(number_b), .round_o(round_b), .led_o(led_b), .total_o(total_b),
        .done_o(done_b)
    );

    typedef struct {
        logic       up;
        logic       down;
        logic       sel;
        int         hold;
        logic [1:0] exp_mode;
        logic [2:0] exp_state;
    } mode_vec_t;

    typedef struct {
        logic [13:0] target;
        int          count;
        logic [15:0] exp_led;
        logic [17:0] exp_total;
    } round_vec_t;

    mode_vec_t  mv[11];
    round_vec_t rv[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press_sel();
        btn_sel = 1'b1;
        tick();
        btn_sel = 1'b0;
        tick();
    endtask

    // From ARM: start, let the count reach 'count' in mode 0, then stop.
    task automatic run_to(input int count);
        press_sel();
        repeat (4 * count - 1) tick();
        press_sel();
    endtask

    initial begin
        mv[0]  = '{1'b1, 1'b0, 1'b0, 1,   2'd2, 3'd0};
        mv[1]  = '{1'b1, 1'b0, 1'b0, 1,   2'd2, 3'd0};
        mv[2]  = '{1'b1, 1'b0, 1'b0, 1,   2'd2, 3'd0};
        mv[3]  = '{1'b0, 1'b1, 1'b0, 1,   2'd1, 3'd0};
        mv[4]  = '{1'b0, 1'b1, 1'b0, 1,   2'd0, 3'd0};
        mv[5]  = '{1'b0, 1'b1, 1'b0, 1,   2'd0, 3'd0};
        mv[6]  = '{1'b0, 1'b1, 1'b0, 1,   2'd0, 3'd0};
        mv[7]  = '{1'b1, 1'b0, 1'b0, 100, 2'd1, 3'd0};
        mv[8]  = '{1'b1, 1'b1, 1'b0, 1,   2'd1, 3'd0};
        mv[9]  = '{1'b0, 1'b1, 1'b0, 1,   2'd0, 3'd0};
        mv[10] = '{1'b1, 1'b0, 1'b1, 1,   2'd0, 3'd1};

        rv[0] = '{14'd5,    5,  16'hFFFF, 18'd0};
        rv[1] = '{14'd100,  5,  16'hFFF8, 18'd95};
        rv[2] = '{14'd1000, 10, 16'h0000, 18'd1085};
        rv[3] = '{14'd15,   5,  16'hFFFF, 18'd10};
        rv[4] = '{14'd40,   20, 16'hFFFF, 18'd30};
        rv[5] = '{14'd5,    35, 16'hFFFE, 18'd60};

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_state",  state_a,  3'd0);
        chk("reset_mode",   mode_a,   2'd1);
        chk("reset_number", number_a, 14'd0);
        chk("reset_round",  round_a,  4'd1);
        chk("reset_led",    led_a,    16'h0);
        chk("reset_total",  total_a,  18'd0);
        chk("reset_done",   done_a,   1'b0);

        rand_in = rv[0].target;
        for (int i = 0; i < 11; i++) begin
            btn_up   = mv[i].up;
            btn_down = mv[i].down;
            btn_sel  = mv[i].sel;
            repeat (mv[i].hold) tick();
            btn_up   = 1'b0;
            btn_down = 1'b0;
            btn_sel  = 1'b0;
            tick();
            chk($sformatf("mode_vec%0d_mode", i),  mode_a,  mv[i].exp_mode);
            chk($sformatf("mode_vec%0d_state", i), state_a, mv[i].exp_state);
        end

        for (int i = 0; i < 6; i++) begin
            chk($sformatf("round%0d_arm_state", i),  state_a,  3'd1);
            chk($sformatf("round%0d_arm_number", i), number_a, rv[i].target);
            chk($sformatf("round%0d_round", i),      round_a,  4'((i % 3) + 1));
            run_to(rv[i].count);
            chk($sformatf("round%0d_score_state", i), state_a,  3'd3);
            chk($sformatf("round%0d_frozen", i),      number_a, 14'(rv[i].count));
            chk($sformatf("round%0d_led", i),         led_a,    rv[i].exp_led);
            chk($sformatf("round%0d_total", i),       total_a,  rv[i].exp_total);
            if (i == 2 || i == 5) begin
                press_sel();
                chk($sformatf("round%0d_done_state", i),  state_a,  3'd4);
                chk($sformatf("round%0d_done_flag", i),   done_a,   1'b1);
                chk($sformatf("round%0d_done_number", i), number_a, rv[i].exp_total[13:0]);
                press_sel();
                chk($sformatf("round%0d_idle_state", i), state_a, 3'd0);
                chk($sformatf("round%0d_idle_round", i), round_a, 4'd1);
                chk($sformatf("round%0d_idle_total", i), total_a, 18'd0);
                chk($sformatf("round%0d_idle_led", i),   led_a,   16'h0);
                chk($sformatf("round%0d_idle_done", i),  done_a,  1'b0);
                chk($sformatf("round%0d_idle_mode", i),  mode_a,  2'd0);
            end
            if (i < 5) begin
                rand_in = rv[i + 1].target;
                press_sel();
            end
        end

        // Zero random value becomes target 1; narrow counter must stick at 15.
        rand_in = 14'd0;
        press_sel();
        chk("zero_target_a", number_a, 14'd1);
        chk("zero_target_b", number_b, 4'd1);
        press_sel();
        repeat (4 * 20 - 1) tick();
        chk("sat_run_b", number_b, 4'd15);
        chk("sat_run_a", number_a, 14'd20);
        press_sel();
        chk("sat_score_total", total_a, 18'd19);
        chk("sat_score_led",   led_a,   16'hFFFF);

        rand_in = 14'd50;
        press_sel();
        chk("midrun_round", round_a, 4'd2);
        press_sel();
        repeat (4 * 7 - 1) tick();
        chk("midrun_count", number_a, 14'd7);
        rst_n = 1'b0;
        tick();
        chk("midrun_rst_state",  state_a,  3'd0);
        chk("midrun_rst_number", number_a, 14'd0);
        chk("midrun_rst_mode",   mode_a,   2'd1);
        chk("midrun_rst_led",    led_a,    16'h0);
        chk("midrun_rst_total",  total_a,  18'd0);
        chk("midrun_rst_round",  round_a,  4'd1);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
